vp_update_sched: RTL and testbench
==================================

# vp_update_sched

Value-prediction update scheduler. It collects per-lane retirement updates from the two-lane VP packet (`result`, `misp`, `actual`, `pc`, `conf`, `valid`) and computes the next confidence for each update. Updates are buffered in a small in-order FIFO and drained one per cycle onto the single write port of the VP confidence/value table, using a valid/ready handshake. It sits between the retirement stage that produces `vp_pkt_t` and the table RAM wrapper.

## Interface

Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `CONF_W`, default `P_CONF_WIDTH`: confidence width, ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `vp_valid`  in  2  per-lane update valid (lane 0 older).
- `vp_pc`  in  2x32  per-lane instruction PC.
- `vp_actual`  in  2x32  per-lane actual result.
- `vp_misp`  in  2  per-lane value mispredict.
- `vp_conf`  in  2xCONF_W  per-lane current confidence.
- `flush`  in  1  synchronous FIFO clear.
- `upd_stall`  out  1  fewer than 2 free entries.
- `tbl_wr_valid`  out  1  head entry valid.
- `tbl_wr_ready`  in  1  table accepts write this cycle.
- `tbl_wr_pc`  out  32  head PC.
- `tbl_wr_data`  out  32  head actual value.
- `tbl_wr_conf`  out  CONF_W  head new confidence.
- `tbl_wr_misp`  out  1  head mispredict flag.
- `drop_cnt`  out  16  saturating count of dropped updates.

## Operation

- New confidence: `misp=1` gives 0. Otherwise `conf+1`, saturating at 2^CONF_W−1.
- Coalescing: if both lanes are valid and `vp_pc[0]==vp_pc[1]`, only lane 1 is enqueued.
- Enqueue order: lane 0 first, then lane 1, into consecutive slots.
- Free slots are computed from the registered count only: `free = DEPTH − count`. A same-cycle dequeue does not create room.
  - 2 updates and free ≥2: both accepted.
  - 2 updates and free =1: lane 0 accepted, lane 1 dropped.
  - 1 update and free ≥1: accepted.
  - free =0: all dropped.
- `drop_cnt` increments by the number of dropped updates (0, 1 or 2) and saturates at 0xFFFF. Coalesced lane 0 does not count as a drop.
- Dequeue occurs when `tbl_wr_valid && tbl_wr_ready`. The head pointer advances by 1.
- Simultaneous enqueue and dequeue: `count_next = count + enq_n − deq`.
- `flush`:
  - count, rd_ptr and wr_ptr are set to 0; `tbl_wr_valid` is 0 the next cycle.
  - Enqueue and dequeue in the same cycle are ignored.
  - `drop_cnt` is unchanged, and updates ignored by flush are not counted.
- Pointers are `log2(DEPTH)` bits and wrap modulo DEPTH. Count is `log2(DEPTH)+1` bits, range 0..DEPTH.

## Timing

- Reset values: all outputs 0; count, pointers, storage and `drop_cnt` 0.
- Reset asserted mid-operation clears state immediately. No write is presented after reset deasserts.
- Enqueue-to-output latency is 1 cycle. An update accepted in cycle N is visible on `tbl_wr_*` in cycle N+1 if the FIFO was empty. There is no combinational bypass.
- `tbl_wr_valid = (count != 0)`; `tbl_wr_*` are driven from head storage.
- Handshake: while `tbl_wr_valid=1` and `tbl_wr_ready=0`, the `tbl_wr_*` outputs hold stable.
- `tbl_wr_valid` never depends combinationally on `tbl_wr_ready`.
- `upd_stall = (DEPTH − count) < 2`, from registered state only. It is advisory: the producer may ignore it, and any resulting losses are counted in `drop_cnt`.
- Throughput: 1 table write per cycle sustained.

## Test plan

- **Single update:** lane 0 with pc=0x1000, actual=0xAB, conf=2, misp=0, `tbl_wr_ready=1`. Next cycle: `tbl_wr_valid=1`, pc=0x1000, data=0xAB, conf=3. Following cycle: `tbl_wr_valid=0`.
- **Dual lane, ordering and saturation:** lane 0 pc=0x10, misp=1, conf=5; lane 1 pc=0x20, conf=max (CONF_W=3, so 7). Writes in order: (0x10, conf 0, misp 1), then (0x20, conf 7).
- **Coalescing:** both lanes with pc=0x40, lane 1 actual=0x99. Exactly one write, with data 0x99; `drop_cnt` stays 0.
- **Full and drop:** `tbl_wr_ready=0`, DEPTH=4, three cycles of dual-lane updates.
  - Count reaches 4.
  - `upd_stall=1` once count ≥3.
  - `drop_cnt=2` after the third cycle.
  - Then `tbl_wr_ready=1`: 4 writes drain in enqueue order, with outputs held stable during backpressure.
- **Simultaneous enqueue/dequeue at count=DEPTH−1 with `flush`:**
  - Without flush: count is unchanged and pointers wrap correctly over 3 DEPTH cycles.
  - Flush asserted with a concurrent update: count becomes 0, no write next cycle, `drop_cnt` unchanged.
- **Reset mid-drain:** assert `rst` asynchronously with count=3. All outputs go to 0 without waiting for a clock edge. After release, `tbl_wr_valid` stays 0 until a new update arrives.

Source files
------------

// File: rtl/vp_update_sched.sv
// Value-prediction update scheduler: collects up to two retirement updates per cycle,
// computes their next confidence, and drains them in order onto one table write port.
module vp_update_sched #(
    parameter int DEPTH  = 4,
    parameter int CONF_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             vp_valid,
    input  logic [1:0][31:0]       vp_pc,
    input  logic [1:0][31:0]       vp_actual,
    input  logic [1:0]             vp_misp,
    input  logic [1:0][CONF_W-1:0] vp_conf,
    input  logic                   flush,
    output logic                   upd_stall,
    output logic                   tbl_wr_valid,
    input  logic                   tbl_wr_ready,
    output logic [31:0]            tbl_wr_pc,
    output logic [31:0]            tbl_wr_data,
    output logic [CONF_W-1:0]      tbl_wr_conf,
    output logic                   tbl_wr_misp,
    output logic [15:0]            drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       data;
        logic [CONF_W-1:0] conf;
        logic              misp;
    } entry_t;

    // A mispredict resets confidence; a correct prediction bumps it, saturating at all-ones.
    function automatic logic [CONF_W-1:0] next_conf(input logic misp, input logic [CONF_W-1:0] conf);
        logic [CONF_W-1:0] res;
        if (misp) begin
            res = '0;
        end else if (&conf) begin
            res = conf;
        end else begin
            res = conf + CONF_W'(1);
        end
        return res;
    endfunction

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic              coalesce_s;
    logic [1:0]        lane_en_s;
    logic [CNT_W-1:0]  free_s;
    logic              deq_s;
    logic [1:0]        req_n_s;
    logic [1:0]        enq_n_s;
    logic [1:0]        drop_n_s;
    logic [16:0]       drop_sum_s;
    logic [PTR_W-1:0]  wr_ptr_p1_s;
    entry_t            lane0_s, lane1_s, first_s, second_s;

    // Lane selection, admission against registered free space, and next-state computation.
    always_comb begin
        lane0_s    = '{pc: vp_pc[0], data: vp_actual[0],
                       conf: next_conf(vp_misp[0], vp_conf[0]), misp: vp_misp[0]};
        lane1_s    = '{pc: vp_pc[1], data: vp_actual[1],
                       conf: next_conf(vp_misp[1], vp_conf[1]), misp: vp_misp[1]};
        coalesce_s = vp_valid[0] & vp_valid[1] & (vp_pc[0] == vp_pc[1]);
        lane_en_s  = {vp_valid[1], vp_valid[0] & ~coalesce_s};
        free_s     = DEPTH_C - count_q;
        deq_s      = (count_q != '0) & tbl_wr_ready;
        req_n_s    = {1'b0, lane_en_s[0]} + {1'b0, lane_en_s[1]};
        first_s    = lane0_s;
        second_s   = lane1_s;
        enq_n_s    = 2'd0;

        case (lane_en_s)
            2'b11: begin
                if (free_s >= CNT_W'(2)) begin
                    enq_n_s = 2'd2;
                end else if (free_s == CNT_W'(1)) begin
                    enq_n_s = 2'd1;
                end else begin
                    enq_n_s = 2'd0;
                end
            end
            2'b01: begin
                enq_n_s = (free_s != '0) ? 2'd1 : 2'd0;
            end
            2'b10: begin
                first_s = lane1_s;
                enq_n_s = (free_s != '0) ? 2'd1 : 2'd0;
            end
            default: begin
                enq_n_s = 2'd0;
            end
        endcase

        drop_n_s    = req_n_s - enq_n_s;
        drop_sum_s  = {1'b0, drop_cnt_q} + 17'(drop_n_s);
        wr_ptr_p1_s = wr_ptr_q + PTR_W'(1);

        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;

        // Flush discards this cycle's traffic entirely, including any would-be drops.
        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            drop_cnt_d = drop_cnt_q;
        end else begin
            if (enq_n_s != 2'd0) begin
                mem_d[wr_ptr_q] = first_s;
            end else begin
                mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
            end
            if (enq_n_s == 2'd2) begin
                mem_d[wr_ptr_p1_s] = second_s;
            end else begin
                mem_d[wr_ptr_p1_s] = mem_q[wr_ptr_p1_s];
            end
            wr_ptr_d   = wr_ptr_q + PTR_W'(enq_n_s);
            rd_ptr_d   = rd_ptr_q + PTR_W'(deq_s);
            count_d    = count_q + CNT_W'(enq_n_s) - CNT_W'(deq_s);
            drop_cnt_d = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
        end
    end

    // State registers; reset clears storage so the head outputs read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= 16'h0000;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign tbl_wr_valid = (count_q != '0);
    assign upd_stall    = (free_s < CNT_W'(2));
    assign tbl_wr_pc    = mem_q[rd_ptr_q].pc;
    assign tbl_wr_data  = mem_q[rd_ptr_q].data;
    assign tbl_wr_conf  = mem_q[rd_ptr_q].conf;
    assign tbl_wr_misp  = mem_q[rd_ptr_q].misp;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_vp_update_sched.sv
// Scoreboard bench for vp_update_sched: expected writes are queued as updates are driven
// and compared against the table write port every cycle.
module tb_vp_update_sched;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        vp_valid = 2'b00;
    logic [1:0][31:0]  vp_pc = '0;
    logic [1:0][31:0]  vp_actual = '0;
    logic [1:0]        vp_misp = 2'b00;
    logic [1:0][CW-1:0] vp_conf = '0;
    logic              flush = 1'b0;
    logic              upd_stall;
    logic              tbl_wr_valid;
    logic              tbl_wr_ready = 1'b0;
    logic [31:0]       tbl_wr_pc;
    logic [31:0]       tbl_wr_data;
    logic [CW-1:0]     tbl_wr_conf;
    logic              tbl_wr_misp;
    logic [15:0]       drop_cnt;

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   data;
        logic [CW-1:0] conf;
        logic          misp;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned m_drop = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    vp_update_sched #(.DEPTH(DEPTH), .CONF_W(CW)) dut (
        .clk(clk), .rst(rst), .vp_valid(vp_valid), .vp_pc(vp_pc), .vp_actual(vp_actual),
        .vp_misp(vp_misp), .vp_conf(vp_conf), .flush(flush), .upd_stall(upd_stall),
        .tbl_wr_valid(tbl_wr_valid), .tbl_wr_ready(tbl_wr_ready), .tbl_wr_pc(tbl_wr_pc),
        .tbl_wr_data(tbl_wr_data), .tbl_wr_conf(tbl_wr_conf), .tbl_wr_misp(tbl_wr_misp),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] model_conf(input logic misp, input logic [CW-1:0] c);
        int unsigned v;
        if (misp) return '0;
        v = int'(c) + 1;
        if (v > (1 << CW) - 1) v = (1 << CW) - 1;
        return CW'(v);
    endfunction

    // Compare outputs mid-cycle, then advance the model by the inputs of this cycle.
    task automatic step();
        int   free_slots;
        exp_t e;
        @(negedge clk);
        check_eq("valid", {31'd0, tbl_wr_valid}, {31'd0, sb_q.size() != 0});
        check_eq("stall", {31'd0, upd_stall}, {31'd0, (DEPTH - sb_q.size()) < 2});
        check_eq("drop_cnt", {16'd0, drop_cnt}, m_drop);
        if (sb_q.size() != 0) begin
            check_eq("pc", tbl_wr_pc, sb_q[0].pc);
            check_eq("data", tbl_wr_data, sb_q[0].data);
            check_eq("conf", {29'd0, tbl_wr_conf}, {29'd0, sb_q[0].conf});
            check_eq("misp", {31'd0, tbl_wr_misp}, {31'd0, sb_q[0].misp});
        end
        if (flush) begin
            sb_q.delete();
        end else begin
            free_slots = DEPTH - sb_q.size();
            if (sb_q.size() != 0 && tbl_wr_ready) void'(sb_q.pop_front());
            for (int l = 0; l < 2; l++) begin
                if (vp_valid[l] && !(l == 0 && vp_valid[1] && vp_pc[0] == vp_pc[1])) begin
                    if (free_slots > 0) begin
                        e.pc = vp_pc[l]; e.data = vp_actual[l];
                        e.conf = model_conf(vp_misp[l], vp_conf[l]); e.misp = vp_misp[l];
                        sb_q.push_back(e);
                        free_slots--;
                    end else begin
                        if (m_drop < 32'hFFFF) m_drop++;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_upd(input logic [1:0] v,
                            input logic [31:0] p0, input logic [31:0] a0, input logic m0, input logic [CW-1:0] c0,
                            input logic [31:0] p1, input logic [31:0] a1, input logic m1, input logic [CW-1:0] c1);
        vp_valid = v;
        vp_pc[0] = p0; vp_actual[0] = a0; vp_misp[0] = m0; vp_conf[0] = c0;
        vp_pc[1] = p1; vp_actual[1] = a1; vp_misp[1] = m1; vp_conf[1] = c1;
        step();
        vp_valid = 2'b00;
    endtask

    task automatic idle(input int n);
        vp_valid = 2'b00;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, {31'd0, tbl_wr_valid}, 32'd0);
        check_eq({tag, "_pc"}, tbl_wr_pc, 32'd0);
        check_eq({tag, "_data"}, tbl_wr_data, 32'd0);
        check_eq({tag, "_conf"}, {29'd0, tbl_wr_conf}, 32'd0);
        check_eq({tag, "_misp"}, {31'd0, tbl_wr_misp}, 32'd0);
        check_eq({tag, "_stall"}, {31'd0, upd_stall}, 32'd0);
        check_eq({tag, "_drop"}, {16'd0, drop_cnt}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Single update, one-cycle latency.
        tbl_wr_ready = 1'b1;
        push_upd(2'b01, 32'h1000, 32'hAB, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 3'd0);
        idle(3);

        // Dual lane ordering, mispredict reset and saturation.
        push_upd(2'b11, 32'h10, 32'h1, 1'b1, 3'd5, 32'h20, 32'h2, 1'b0, 3'd7);
        idle(3);

        // Coalescing: only lane 1 survives, no drop.
        push_upd(2'b11, 32'h40, 32'h11, 1'b0, 3'd1, 32'h40, 32'h99, 1'b0, 3'd4);
        idle(2);

        // Fill under backpressure, drop two, then drain in order.
        tbl_wr_ready = 1'b0;
        push_upd(2'b11, 32'h100, 32'hA0, 1'b0, 3'd0, 32'h104, 32'hA1, 1'b0, 3'd1);
        push_upd(2'b11, 32'h108, 32'hA2, 1'b1, 3'd2, 32'h10C, 32'hA3, 1'b0, 3'd6);
        push_upd(2'b11, 32'h110, 32'hA4, 1'b0, 3'd3, 32'h114, 32'hA5, 1'b0, 3'd4);
        idle(3);
        tbl_wr_ready = 1'b1;
        idle(6);

        // Hold count at DEPTH-1 with concurrent enqueue/dequeue, then flush with an update.
        tbl_wr_ready = 1'b0;
        push_upd(2'b11, 32'h200, 32'hB0, 1'b0, 3'd1, 32'h204, 32'hB1, 1'b0, 3'd2);
        push_upd(2'b01, 32'h208, 32'hB2, 1'b0, 3'd3, 32'h0, 32'h0, 1'b0, 3'd0);
        tbl_wr_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            push_upd(2'b10, 32'h0, 32'h0, 1'b0, 3'd0, 32'h300 + 32'(i * 4), 32'hC0 + 32'(i), 1'b0, 3'(i));
        end
        flush = 1'b1;
        push_upd(2'b11, 32'h400, 32'hD0, 1'b0, 3'd0, 32'h404, 32'hD1, 1'b0, 3'd0);
        flush = 1'b0;
        idle(2);

        // Asynchronous reset with three entries pending.
        tbl_wr_ready = 1'b0;
        push_upd(2'b11, 32'h500, 32'hE0, 1'b0, 3'd1, 32'h504, 32'hE1, 1'b0, 3'd2);
        push_upd(2'b01, 32'h508, 32'hE2, 1'b1, 3'd3, 32'h0, 32'h0, 1'b0, 3'd0);
        idle(1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        sb_q.delete();
        m_drop = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tbl_wr_ready = 1'b1;
        idle(3);

        // Randomised traffic with backpressure and occasional flush.
        for (int i = 0; i < 400; i++) begin
            tbl_wr_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            push_upd(2'($urandom_range(0, 3)),
                     32'h600 + 32'($urandom_range(0, 2) * 4), $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     32'h600 + 32'($urandom_range(0, 2) * 4), $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            flush = 1'b0;
        end
        tbl_wr_ready = 1'b1;
        idle(DEPTH + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
